// File: rtl/my_alu_pkg.sv
// Shared ALU control encoding and the multiplier state type.
package my_alu_pkg;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_X_PLUS_Y = '{zx: 1'b0, nx: 1'b0, zy: 1'b0, ny: 1'b0, f: 1'b1, no: 1'b0};
  localparam alu_ctrl_t ALU_X        = '{zx: 1'b0, nx: 1'b0, zy: 1'b1, ny: 1'b1, f: 1'b0, no: 1'b0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/my_alu.sv
// 16-bit zero/negate ALU: optional zero and invert on each operand, add or AND, optional invert of result.
module my_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out
);

  logic [15:0] x_z, x_n, y_z, y_n, fn;

  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    fn  = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~fn : fn;
  end

endmodule

// File: rtl/my_mul_seq.sv
// Sequential 16-bit shift-and-add multiplier driving one shared my_alu instance.
module my_mul_seq
  import my_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        product_zr,
  output logic        product_ng
);

  mul_state_t  state, state_nxt;
  logic [15:0] acc, mcand, mplier;
  logic [15:0] alu_x, alu_y, alu_out;
  alu_ctrl_t   ctrl;

  my_alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (ctrl.zx),
    .nx  (ctrl.nx),
    .zy  (ctrl.zy),
    .ny  (ctrl.ny),
    .f   (ctrl.f),
    .no  (ctrl.no),
    .out (alu_out)
  );

  always_comb begin
    state_nxt = state;
    alu_x     = acc;
    alu_y     = mcand;
    ctrl      = ALU_X;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ADD;
      end
      ADD: begin
        if (mplier == '0) begin
          state_nxt = DONE;
        end else begin
          ctrl      = mplier[0] ? ALU_X_PLUS_Y : ALU_X;
          state_nxt = DBL;
        end
      end
      DBL: begin
        alu_x     = mcand;
        ctrl      = ALU_X_PLUS_Y;
        state_nxt = ADD;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
          end
        end
        ADD: begin
          if (mplier != '0) acc <= alu_out;
        end
        DBL: begin
          mcand  <= alu_out;
          mplier <= mplier >> 1;
        end
        default: ;
      endcase
    end
  end

  assign product    = acc;
  assign product_zr = (acc == '0);
  assign product_ng = acc[15];

endmodule

// File: tb/tb_my_mul_seq.sv
// Scoreboard bench for my_mul_seq: driver queues expected results, monitor checks each output handshake.
module tb_my_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        product_zr;
  logic        product_ng;

  my_mul_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .product_zr (product_zr),
    .product_ng (product_ng)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] p;
    logic        zr;
    logic        ng;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency measured from the handshake cycle to the first cycle out_valid is seen.
  initial begin : monitor
    logic prev_ov;
    int   rise_cyc;
    exp_t e;
    prev_ov  = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) rise_cyc = cyc;
        prev_ov = out_valid;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("product", {16'd0, product}, {16'd0, e.p});
            chk("product_zr", {31'd0, product_zr}, {31'd0, e.zr});
            chk("product_ng", {31'd0, product_ng}, {31'd0, e.ng});
            chk("latency", rise_cyc - e.acc_cyc, e.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] ep,
                       input logic ezr, input logic eng, input int elat);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    e.p = ep; e.zr = ezr; e.ng = eng; e.lat = elat; e.acc_cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_product"}, {16'd0, product}, 32'd0);
    chk({tag, "_zr"}, {31'd0, product_zr}, 32'd1);
    chk({tag, "_ng"}, {31'd0, product_ng}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int t;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #2;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    issue(16'd3,     16'd5,     16'h000F, 1'b0, 1'b0, 8);
    drain();
    issue(16'hFFFE,  16'd7,     16'hFFF2, 1'b0, 1'b1, 8);
    drain();
    issue(16'h0100,  16'h0100,  16'h0000, 1'b1, 1'b0, 20);
    drain();
    issue(16'h1234,  16'h0000,  16'h0000, 1'b1, 1'b0, 2);
    drain();

    // Result stall with an ignored in_valid pulse while in DONE.
    out_ready = 1'b0;
    issue(16'h0001, 16'h8000, 16'h8000, 1'b0, 1'b1, 34);
    t = 0;
    while (!out_valid && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk("stall_out_valid_wait", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_product", {16'd0, product}, 32'h8000);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = (i == 1);
      a        = 16'd5;
      b        = 16'd5;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_done_out_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset mid-operation aborts with no result.
    a        = 16'd9;
    b        = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_valid", {31'd0, out_valid}, 32'd0);

    issue(16'd2, 16'd3, 16'd6, 1'b0, 1'b0, 6);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
